// File: rtl/tetris_pkg.sv
// Shared playfield types, constants and helpers for the Tetris datapath.
// Row 0 is the top row; cell c of a row sits at bits [c*CELL_W +: CELL_W].
package tetris_pkg;

   localparam int ROWS   = 20;
   localparam int COLS   = 10;
   localparam int CELL_W = 4;

   typedef logic [CELL_W-1:0] cell_t;
   typedef cell_t [COLS-1:0]  row_t;

   typedef enum logic [2:0] {
      LC_IDLE,
      LC_SCAN,
      LC_FLASH,
      LC_SHIFT,
      LC_DONE
   } lc_state_t;

   function automatic logic row_full(row_t r);
      logic f;
      f = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (r[c] == cell_t'(0)) begin
            f = 1'b0;
         end
      end
      return f;
   endfunction

   function automatic logic [15:0] line_score(logic [2:0] n);
      logic [15:0] s;
      case (n)
         3'd0:    s = 16'd0;
         3'd1:    s = 16'd40;
         3'd2:    s = 16'd100;
         3'd3:    s = 16'd300;
         default: s = 16'd1200;
      endcase
      return s;
   endfunction

   // Row count can exceed 7 only on an impossible grid; clamp it.
   function automatic logic [2:0] sat_popcount(logic [ROWS-1:0] m);
      int n;
      n = 0;
      for (int r = 0; r < ROWS; r++) begin
         n += int'(m[r]);
      end
      return (n > 7) ? 3'd7 : 3'(n);
   endfunction

endpackage

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scan rows, mark full ones, optionally flash, compact.
// Define LINE_CLEAR_FLASH_EN to build the FLASH blink phase.
module line_clear_ctrl
   import tetris_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [4:0]               rd_row,
   input  logic [COLS*CELL_W-1:0]   rd_data,
   output logic                     wr_en,
   output logic [4:0]               wr_row,
   output logic [COLS*CELL_W-1:0]   wr_data,
   output logic [ROWS-1:0]          flash_mask,
   output logic [2:0]               lines_cleared,
   output logic [15:0]              score_add
);

`ifdef LINE_CLEAR_FLASH_EN
   localparam int FLASH_CYCLES = 24;
   localparam int FLASH_HALF   = 6;
   localparam int FC_W         = $clog2(FLASH_CYCLES);
`endif

   lc_state_t         state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [ROWS-1:0]   full_mask_q, full_mask_d;
   // src uses bit 5 as the "below row 0" sign flag
   logic [5:0]        src_q, src_d;
   logic [4:0]        dst_q, dst_d;
   logic [2:0]        lines_q, lines_d;
   logic [15:0]       score_q, score_d;
`ifdef LINE_CLEAR_FLASH_EN
   logic [FC_W-1:0]   flash_cnt_q, flash_cnt_d;
`endif

   logic src_live;
   assign src_live = ~src_q[5];

   // State register and pass bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LC_IDLE;
         cnt_q       <= '0;
         full_mask_q <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         lines_q     <= '0;
         score_q     <= '0;
`ifdef LINE_CLEAR_FLASH_EN
         flash_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         full_mask_q <= full_mask_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         lines_q     <= lines_d;
         score_q     <= score_d;
`ifdef LINE_CLEAR_FLASH_EN
         flash_cnt_q <= flash_cnt_d;
`endif
      end
   end

   // Next-state logic and combinational grid port drive
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      full_mask_d = full_mask_q;
      src_d       = src_q;
      dst_d       = dst_q;
      lines_d     = lines_q;
      score_d     = score_q;
`ifdef LINE_CLEAR_FLASH_EN
      flash_cnt_d = flash_cnt_q;
`endif
      busy       = (state_q != LC_IDLE);
      done       = 1'b0;
      rd_row     = '0;
      wr_en      = 1'b0;
      wr_row     = '0;
      wr_data    = '0;
      flash_mask = '0;

      unique case (state_q)
         LC_IDLE: begin
            if (start) begin
               state_d     = LC_SCAN;
               cnt_d       = '0;
               full_mask_d = '0;
               lines_d     = '0;
               score_d     = '0;
            end
         end

         LC_SCAN: begin
            rd_row = cnt_q;
            full_mask_d[cnt_q] = row_full(row_t'(rd_data));
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(ROWS-1)) begin
               lines_d = sat_popcount(full_mask_d);
               score_d = line_score(lines_d);
               src_d   = 6'(ROWS-1);
               dst_d   = 5'(ROWS-1);
`ifdef LINE_CLEAR_FLASH_EN
               flash_cnt_d = '0;
               state_d = (|full_mask_d) ? LC_FLASH : LC_DONE;
`else
               state_d = (|full_mask_d) ? LC_SHIFT : LC_DONE;
`endif
            end
         end

         LC_FLASH: begin
`ifdef LINE_CLEAR_FLASH_EN
            if (((int'(flash_cnt_q) / FLASH_HALF) % 2) == 0) begin
               flash_mask = full_mask_q;
            end
            flash_cnt_d = flash_cnt_q + 1'b1;
            if (flash_cnt_q == FC_W'(FLASH_CYCLES-1)) begin
               state_d = LC_SHIFT;
            end
`else
            state_d = LC_SHIFT;
`endif
         end

         LC_SHIFT: begin
            if (src_live) begin
               rd_row = src_q[4:0];
            end
            if (src_live && full_mask_q[src_q[4:0]]) begin
               src_d = src_q - 6'd1;
            end else begin
               wr_en   = 1'b1;
               wr_row  = dst_q;
               wr_data = src_live ? rd_data : '0;
               if (src_live) begin
                  src_d = src_q - 6'd1;
               end
               dst_d = dst_q - 5'd1;
               if (dst_q == 5'd0) begin
                  state_d = LC_DONE;
               end
            end
         end

         LC_DONE: begin
            done    = 1'b1;
            state_d = LC_IDLE;
         end

         default: begin
            state_d = LC_IDLE;
         end
      endcase
   end

   assign lines_cleared = lines_q;
   assign score_add     = score_q;

endmodule

// File: doc/line_clear_ctrl.md
# line_clear_ctrl

Sequencer that runs the Tetris line-clear pass after a piece locks into the playfield grid. It scans every row through a one-row read port, marks full rows, optionally flashes them for the renderer, then compacts the grid bottom-up through a one-row write port and reports lines cleared and score increment. It sits between the game-logic FSM (which pulses `start` on lock) and the grid storage that the renderer also reads.

## Interface
- `ROWS`, 20, playfield rows; row 0 is the top row.
- `COLS`, 10, playfield columns.
- `CELL_W`, 4, bits per cell; 0 means empty, 1..7 are the piece color index.
- `FLASH_CYCLES`, 24, total cycles spent in FLASH.
- `FLASH_HALF`, 6, blink half-period in cycles.

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle lock pulse; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `rd_row` out 5: grid read row address.
- `rd_data` in COLS*CELL_W: row contents, combinational, same cycle. Cell c is at bits [c*CELL_W +: CELL_W].
- `wr_en` out 1: grid row write strobe.
- `wr_row` out 5: write row address.
- `wr_data` out COLS*CELL_W: row write data.
- `flash_mask` out ROWS: bit r high means the renderer draws row r as white.
- `lines_cleared` out 3: 0..4. Valid while `done` is high; holds its value until the next `start`.
- `score_add` out 16: score increment. Valid while `done` is high; holds its value until the next `start`.

## Operation
- States:
  - IDLE → SCAN on `start`.
  - SCAN → FLASH if any row is full, else → DONE.
  - FLASH → SHIFT.
  - SHIFT → DONE.
  - DONE → IDLE.
- SCAN
  - `rd_row` counts 0..ROWS-1, one row per cycle.
  - A row is full when all COLS cells are nonzero. Bit r of the internal `full_mask` latches the result for row r.
  - `lines_cleared` = popcount of `full_mask`, saturated to 3 bits.
- FLASH
  - A counter runs for FLASH_CYCLES cycles.
  - `flash_mask` = `full_mask` while (counter / FLASH_HALF) is even, else 0.
  - `flash_mask` is 0 in every other state.
- SHIFT
  - Two pointers: `src` and `dst`, both starting at ROWS-1.
  - `rd_row` = `src` while `src` ≥ 0.
  - Each cycle takes the first matching case:
    - `src` ≥ 0 and `full_mask[src]`: no write, `src` decrements.
    - `src` ≥ 0: write `rd_data` to `dst`, then both pointers decrement.
    - `src` < 0: write all-zero data to `dst`, `dst` decrements.
  - SHIFT exits after the write to `dst`=0.
  - Every row is written exactly once, so SHIFT lasts ROWS + `lines_cleared` cycles.
- Score lookup by `lines_cleared`: 0→0, 1→40, 2→100, 3→300, 4→1200. Any value above 4 cannot occur; it maps to 1200.
- `start` is ignored while `busy` is high; it is not queued.

## Timing
- Reset values: state IDLE; `busy`, `done`, `wr_en` = 0; `rd_row`, `wr_row`, `wr_data`, `flash_mask`, `lines_cleared`, `score_add` = 0; `full_mask` = 0.
- Cycle numbering: `start` sampled at edge T; SCAN occupies T+1..T+ROWS.
- No full rows: DONE at T+ROWS+1, with `lines_cleared`=0 and no write issued.
- n full rows: FLASH occupies FLASH_CYCLES cycles, then SHIFT occupies ROWS+n cycles, then DONE for 1 cycle.
- `wr_en` and `wr_data` are registered-free combinational from state and pointers. The grid commits the write at the end of that cycle.
- Reset mid-operation:
  - Immediate return to IDLE; no further writes.
  - A partially compacted grid is left as-is; the game FSM restarts the game on reset.

## Configuration
- `LINE_CLEAR_FLASH_EN`
  - Defined: FLASH state present, behaving as above.
  - Undefined: SCAN goes directly to SHIFT when any row is full; `flash_mask` is tied to 0; the FLASH counter is not built.
  - With it undefined, n full rows give DONE at T+ROWS+1+ROWS+n.

## Structure
- Shared package `tetris_pkg` holds:
  - `ROWS` and `COLS` constants.
  - `cell_t` (logic [3:0]) and `row_t` (`cell_t` [COLS]) typedefs.
  - Function `row_full(row_t)`.
  - Function `line_score(logic [2:0])`.
  - The FSM state enum `lc_state_t`.
- No sub-module is needed; the block is one FSM plus its counters.

## Test plan
- Empty grid, `start` pulse → `done` at T+21, `lines_cleared`=0, `score_add`=0, zero writes.
- Row 19 full, all other rows empty → `flash_mask` = bit 19 blinking, toggling every 6 cycles. Then 21 SHIFT cycles (one skip plus 20 writes), row 19 ends all zeros, `score_add`=40.
- Rows 16..19 full, row 15 = pattern P → after SHIFT, row 19 = P and rows 0..18 = 0. `lines_cleared`=4, `score_add`=1200.
- Rows 17 and 19 full, row 18 = A, row 16 = B → final row 19 = A, row 18 = B. `score_add`=100.
- `start` held high through the whole pass → exactly one pass runs. A new pass starts only from IDLE, on the cycle after DONE.
- `rst_n` low mid-SHIFT → `busy`, `wr_en`, `flash_mask` go to 0 asynchronously; state is IDLE after release.
